// File: rtl/fc_result_writer.sv
// fc_result_writer: streams an fc_layer output-node vector into FCmemory.
// Optional ReLU at write time when FC_WB_RELU_EN is defined.
module fc_result_writer #(
  parameter int NUM_NODES = 84,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 14,
  parameter int BASE_ADDR = 10284
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_NODES*DATA_W-1:0] node_data,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W-1:0]           mem_address,
  output logic [DATA_W-1:0]           mem_data_in,
  output logic                        mem_write_enable
);

  localparam int IW = $clog2(NUM_NODES + 1);
  localparam logic [IW-1:0] LAST = IW'(NUM_NODES);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  state_t                      r_state;
  logic [IW-1:0]               r_idx;
  logic [NUM_NODES*DATA_W-1:0] r_shadow;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_we;
  logic [ADDR_W-1:0]           r_addr;
  logic [DATA_W-1:0]           r_data;
  logic [DATA_W-1:0]           w_word;

  function automatic logic [DATA_W-1:0] f_wb(
    input logic [DATA_W-1:0] x
  );
`ifdef FC_WB_RELU_EN
    return x[DATA_W-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // word of the shadow selected by the next index to present
  assign w_word = r_shadow[r_idx*DATA_W +: DATA_W];

  // FSM: node 0 is presented on the accepting edge straight from
  // node_data, so r_idx holds the index of the next word to present
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shadow <= node_data;
            r_addr   <= BASE;
            r_data   <= f_wb(node_data[DATA_W-1:0]);
            r_we     <= 1'b1;
            r_busy   <= 1'b1;
            r_idx    <= IW'(1);
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_idx == LAST) begin
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_addr <= BASE + ADDR_W'(r_idx);
            r_data <= f_wb(w_word);
            r_idx  <= r_idx + IW'(1);
          end
        end
      endcase
    end
  end

  assign busy             = r_busy;
  assign done             = r_done;
  assign mem_address      = r_addr;
  assign mem_data_in      = r_data;
  assign mem_write_enable = r_we;

endmodule
